// File: rtl/inv_key_expand128_if.sv
// Handshake bundle for the inverse AES-128 key expander: last roundkey in,
// roundkeys out in descending round order.
interface inv_key_expand128_if;
  logic [0:127] kl;
  logic         kl_vld;
  logic         kl_rdy;
  logic [0:127] rkey;
  logic [0:3]   rkey_round;
  logic         rkey_vld;
  logic         rkey_rdy;
  logic         rkey_last;

  modport master (
    output kl, kl_vld, rkey_rdy,
    input  kl_rdy, rkey, rkey_round, rkey_vld, rkey_last
  );

  modport slave (
    input  kl, kl_vld, rkey_rdy,
    output kl_rdy, rkey, rkey_round, rkey_vld, rkey_last
  );
endinterface

// File: rtl/inv_key_expand128.sv
// Inverse AES-128 key schedule: takes the round-10 key and walks back to the
// cipher key, one roundkey per accepted handshake.
module aes_rot_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  assign word_o = {word_i[23:0], word_i[31:24]};
endmodule

module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  localparam logic [0:2047] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

module inv_key_expand128 (
  input  logic                clk,
  input  logic                rst,
  inv_key_expand128_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [4];
  logic [31:0] w_d [4];
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;

  logic [31:0] w3_prev, w3_rot, w3_sub;

  // The previous w3 must be recovered first; it feeds the g() path for w0.
  assign w3_prev = w_q[3] ^ w_q[2];

  aes_rot_word u_rot (.word_i(w3_prev), .word_o(w3_rot));
  aes_sub_word u_sub (.word_i(w3_rot),  .word_o(w3_sub));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (bus.kl_vld) begin
          w_d[0]  = bus.kl[0:31];
          w_d[1]  = bus.kl[32:63];
          w_d[2]  = bus.kl[64:95];
          w_d[3]  = bus.kl[96:127];
          round_d = 4'd10;
          rcon_d  = 8'h36;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.rkey_rdy) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            w_d[3]  = w3_prev;
            w_d[2]  = w_q[2] ^ w_q[1];
            w_d[1]  = w_q[1] ^ w_q[0];
            w_d[0]  = w_q[0] ^ w3_sub ^ {rcon_q, 24'h0};
            round_d = round_q - 4'd1;
            // Inverse xtime: undo the GF(2^8) doubling of the forward Rcon.
            rcon_d  = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80)
                                : (rcon_q >> 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      round_q <= '0;
      rcon_q  <= 8'h36;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign bus.kl_rdy     = (state_q == IDLE);
  assign bus.rkey_vld   = (state_q == RUN);
  assign bus.rkey       = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign bus.rkey_round = round_q;
  assign bus.rkey_last  = (state_q == RUN) && (round_q == 4'd0);
endmodule

// File: doc/inv_key_expand128.md
INV_KEY_EXPAND128 -- requirements
Module: inv_key_expand128

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port kl, input, [0:127]: last (round-10) AES-128 roundkey; w0=kl[0:31] .. w3=kl[96:127].
REQ-004 SHALL have port kl_vld, input, 1 bit: high = valid last roundkey present on kl.
REQ-005 SHALL have port kl_rdy, output, 1 bit: high = block accepts a new kl this cycle.
REQ-006 SHALL have port rkey, output, [0:127]: current roundkey, issued in descending round order 10..0.
REQ-007 SHALL have port rkey_round, output, [0:3]: round index of rkey, 10 down to 0.
REQ-008 SHALL have port rkey_vld, output, 1 bit: high = rkey/rkey_round valid.
REQ-009 SHALL have port rkey_rdy, input, 1 bit: high = consumer takes rkey this cycle.
REQ-010 SHALL have port rkey_last, output, 1 bit: high when the valid rkey is round 0 (the cipher key).

Function
REQ-011 SHALL implement a two-state FSM: IDLE, RUN.
REQ-012 SHALL drive kl_rdy=1 in IDLE and kl_rdy=0 in RUN.
REQ-013 SHALL, in IDLE with kl_vld=1, register kl into w0..w3, set round counter=10, set Rcon=8'h36, and enter RUN next cycle.
REQ-014 SHALL ignore kl and kl_vld while in RUN.
REQ-015 SHALL drive rkey={w0,w1,w2,w3}, rkey_round=round counter, and rkey_vld=1 in RUN; rkey_vld=0 in IDLE.
REQ-016 SHALL present the first key (round 10, equal to kl) exactly one cycle after kl acceptance; no combinational path from kl to rkey.
REQ-017 SHALL drive rkey_last=1 iff in RUN and round counter=0.
REQ-018 SHALL hold rkey, rkey_round, and all internal state unchanged while rkey_vld=1 and rkey_rdy=0.
REQ-019 SHALL, on a RUN cycle with rkey_rdy=1 and round counter>0, update to the previous roundkey:
 - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
 - w0'=w0^SubWord(RotWord(w3'))^{Rcon,24'h0}
 - round counter decrements by 1.
REQ-020 SHALL, in the same step, update Rcon by inverse xtime: if Rcon[7] (LSB)=1 then Rcon'=((Rcon^8'h1b)>>1)|8'h80, else Rcon'=Rcon>>1; sequence 36,1b,80,40,20,10,08,04,02,01.
REQ-021 SHALL reuse the team's existing RotWord and SubWord combinational blocks for the w0' computation.
REQ-022 SHALL, on a RUN cycle with rkey_rdy=1 and round counter=0, return to IDLE; kl_rdy=1 the following cycle.
REQ-023 SHALL sustain one key per cycle with rkey_rdy held high: 11 keys in 11 consecutive cycles.
REQ-024 SHALL have a minimum of one IDLE cycle between consecutive key schedules; a kl_vld held high is accepted on that IDLE cycle.
REQ-025 SHALL treat rkey_rdy as don't-care when rkey_vld=0.

Reset
REQ-026 SHALL, while rst=1, force IDLE, round counter=0, Rcon=8'h36, w0..w3=0, which gives outputs rkey_vld=0, rkey_last=0, kl_rdy=1, rkey=0, rkey_round=0.
REQ-027 SHALL, on rst asserted mid-schedule, abandon the schedule at the next edge with no further keys issued; rst has priority over kl_vld and rkey_rdy.

Verification
REQ-028 SHALL test FIPS-197 A.1 with rkey_rdy=1 throughout:
 - stimulus: kl=d014f9a8c9ee2589e13f0cc8b6630ca6
 - response: round 10 = kl; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605
 - round 0 = 2b7e151628aed2a6abf7158809cf4f3c with rkey_last=1.
REQ-029 SHALL test backpressure: rkey_rdy toggled pseudo-randomly -> same 11-key sequence, rkey stable while rkey_rdy=0, no key skipped or duplicated.
REQ-030 SHALL test busy rejection: kl_vld pulsed with a different key during RUN -> kl_rdy=0 and the output sequence is unaffected.
REQ-031 SHALL test back-to-back loads: kl_vld held high with two keys -> second schedule starts one cycle after first rkey_last handshake, with exactly one IDLE cycle between.
REQ-032 SHALL test reset mid-schedule: rst at round 5 -> next cycle rkey_vld=0, kl_rdy=1; a new kl is then expanded correctly from round 10.
REQ-033 SHALL test a loopback check: 100 random cipher keys through the forward expander, its last roundkey fed to kl -> reversed 11-key sequence matches the forward sequence bit-exactly.
